// File: rtl/n64adv_vout_align.sv
// Frame-synchronous output aligner: delays colour and sync fields of a packed video word
// by independent run-time delays (0..MAX_DLY) through a single ring buffer.
module n64adv_vout_align #(
    parameter  int COLOR_WIDTH = 8,
    parameter  int NUM_CH      = 3,
    parameter  int SYNC_W      = 4,
    parameter  int MAX_DLY     = 7,
    localparam int DW          = $clog2(MAX_DLY + 1),
    localparam int VW          = SYNC_W + NUM_CH * COLOR_WIDTH
) (
    input  logic          VCLK,
    input  logic          nRST,
    input  logic [VW-1:0] vdata_i,
    input  logic [DW-1:0] dly_color_i,
    input  logic [DW-1:0] dly_sync_i,
    input  logic          blank_i,
    output logic [VW-1:0] vdata_o,
    output logic          VSYNC_o,
    output logic          HSYNC_o,
    output logic          dly_pending_o
);

    localparam int            DEPTH   = 2 ** DW;
    localparam int            CW      = NUM_CH * COLOR_WIDTH;
    localparam int            VS_BIT  = VW - SYNC_W + 3;
    localparam int            HS_BIT  = VW - SYNC_W + 1;
    localparam logic [DW-1:0] MAX_SEL = DW'(MAX_DLY);

    logic [VW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_wr_ptr;
    logic [DW-1:0] r_act_c;
    logic [DW-1:0] r_act_s;
    logic          r_vsync_prev;

    logic [DW-1:0] w_req_c;
    logic [DW-1:0] w_req_s;
    logic [DW-1:0] w_next_act_c;
    logic [DW-1:0] w_next_act_s;
    logic [DW-1:0] w_rd_c;
    logic [DW-1:0] w_rd_s;
    logic [VW-1:0] w_word_c;
    logic [VW-1:0] w_word_s;
    logic [VW-1:0] w_vdata;
    logic          w_fe;

    always_comb begin
        w_req_c      = (int'(dly_color_i) > MAX_DLY) ? MAX_SEL : dly_color_i;
        w_req_s      = (int'(dly_sync_i)  > MAX_DLY) ? MAX_SEL : dly_sync_i;
        w_fe         = r_vsync_prev & ~vdata_i[VS_BIT];
        w_next_act_c = w_fe ? w_req_c : r_act_c;
        w_next_act_s = w_fe ? w_req_s : r_act_s;

        // A zero delay would otherwise address the slot about to be overwritten,
        // i.e. the oldest entry, so the incoming word is forwarded instead.
        w_rd_c       = r_wr_ptr - r_act_c;
        w_rd_s       = r_wr_ptr - r_act_s;
        w_word_c     = (r_act_c == '0) ? vdata_i : r_mem[w_rd_c];
        w_word_s     = (r_act_s == '0) ? vdata_i : r_mem[w_rd_s];

        w_vdata      = {w_word_s[VW-1 -: SYNC_W],
                        blank_i ? {CW{1'b0}} : w_word_c[CW-1:0]};
    end

    always_ff @(posedge VCLK or negedge nRST) begin
        if (!nRST) begin
            // NOTE: the buffer is reset explicitly so a reset mid-frame never replays stale history.
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr      <= '0;
            r_act_c       <= '0;
            r_act_s       <= '0;
            r_vsync_prev  <= 1'b0;
            vdata_o       <= '0;
            VSYNC_o       <= 1'b0;
            HSYNC_o       <= 1'b0;
            dly_pending_o <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_mem[r_wr_ptr] <= vdata_i;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
            r_vsync_prev    <= vdata_i[VS_BIT];
            r_act_c         <= w_next_act_c;
            r_act_s         <= w_next_act_s;
            vdata_o         <= w_vdata;
            VSYNC_o         <= vdata_o[VS_BIT];
            HSYNC_o         <= vdata_o[HS_BIT];
            dly_pending_o   <= (w_req_c != w_next_act_c) | (w_req_s != w_next_act_s);
        end
    end

endmodule

// File: tb/tb_n64adv_vout_align.sv
// Directed bench for n64adv_vout_align (MAX_DLY=5): scenario table plus hand-written
// sequences for same-cycle switch, request revert, blanking and mid-frame reset.
module tb_n64adv_vout_align;

    localparam int COLOR_WIDTH = 8;
    localparam int NUM_CH      = 3;
    localparam int SYNC_W      = 4;
    localparam int MAX_DLY     = 5;
    localparam int DW          = $clog2(MAX_DLY + 1);
    localparam int VW          = SYNC_W + NUM_CH * COLOR_WIDTH;
    localparam int CW          = NUM_CH * COLOR_WIDTH;

    logic          VCLK = 1'b0;
    logic          nRST = 1'b0;
    logic [VW-1:0] vdata_i = '0;
    logic [DW-1:0] dly_color_i = '0;
    logic [DW-1:0] dly_sync_i = '0;
    logic          blank_i = 1'b0;
    logic [VW-1:0] vdata_o;
    logic          VSYNC_o;
    logic          HSYNC_o;
    logic          dly_pending_o;

    n64adv_vout_align #(
        .COLOR_WIDTH(COLOR_WIDTH),
        .NUM_CH     (NUM_CH),
        .SYNC_W     (SYNC_W),
        .MAX_DLY    (MAX_DLY)
    ) u_dut (
        .VCLK         (VCLK),
        .nRST         (nRST),
        .vdata_i      (vdata_i),
        .dly_color_i  (dly_color_i),
        .dly_sync_i   (dly_sync_i),
        .blank_i      (blank_i),
        .vdata_o      (vdata_o),
        .VSYNC_o      (VSYNC_o),
        .HSYNC_o      (HSYNC_o),
        .dly_pending_o(dly_pending_o)
    );

    always #5 VCLK = ~VCLK;

    typedef struct {
        logic [DW-1:0] dly_c;
        logic [DW-1:0] dly_s;
        int            exp_c;
        int            exp_s;
        int            pre;
        int            post;
    } scen_t;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [VW-1:0] hist [0:2047];
    int            t = 0;
    int            base = 0;
    int            lat_c = 0;
    int            lat_s = 0;
    int            req_c = 0;
    int            req_s = 0;
    logic [VW-1:0] prev_exp = '0;
    scen_t         scen [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0d got %h expected %h", name, t, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] mkword(input int tt, input logic vs);
        logic [7:0] c;
        c = tt[7:0];
        return {vs, tt[0], tt[1], tt[2], c, ~c, c ^ 8'h5A};
    endfunction

    function automatic logic [VW-1:0] past(input int k);
        int idx;
        idx = t - k;
        if (idx < base) return '0;
        return hist[idx];
    endfunction

    task automatic set_req(input logic [DW-1:0] dc, input logic [DW-1:0] ds,
                           input int exp_c, input int exp_s);
        dly_color_i = dc;
        dly_sync_i  = ds;
        req_c       = exp_c;
        req_s       = exp_s;
    endtask

    // One video cycle: drive a word, let the edge happen, compare all outputs.
    task automatic tick(input logic vs, input bit fe, input string tag);
        logic [VW-1:0] w;
        logic [VW-1:0] ws;
        logic [VW-1:0] wc;
        logic [VW-1:0] exp;
        w       = mkword(t, vs);
        hist[t] = w;
        vdata_i = w;
        @(posedge VCLK);
        #1;
        ws  = past(lat_s);
        wc  = past(lat_c);
        exp = {ws[VW-1 -: SYNC_W], blank_i ? {CW{1'b0}} : wc[CW-1:0]};
        check({tag, ".vdata_o"}, 64'(vdata_o), 64'(exp));
        check({tag, ".VSYNC_o"}, 64'(VSYNC_o), 64'(prev_exp[VW-1]));
        check({tag, ".HSYNC_o"}, 64'(HSYNC_o), 64'(prev_exp[VW-3]));
        if (fe) begin
            lat_c = req_c;
            lat_s = req_s;
        end
        check({tag, ".pending"}, 64'(dly_pending_o), 64'((req_c != lat_c) || (req_s != lat_s)));
        prev_exp = exp;
        t++;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".vdata_o"}, 64'(vdata_o), 64'd0);
        check({tag, ".VSYNC_o"}, 64'(VSYNC_o), 64'd0);
        check({tag, ".HSYNC_o"}, 64'(HSYNC_o), 64'd0);
        check({tag, ".pending"}, 64'(dly_pending_o), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout t=%0d", t);
        $fatal(1, "timeout");
    end

    initial begin
        // dly_c, dly_s, expected act_c, expected act_s (hand-clamped), pre, post
        scen[0] = '{3'd3, 3'd0, 3, 0, 3, 10};
        scen[1] = '{3'd7, 3'd0, 5, 0, 2, 40};
        scen[2] = '{3'd0, 3'd2, 0, 2, 2, 10};
        scen[3] = '{3'd5, 3'd5, 5, 5, 2, 10};
        scen[4] = '{3'd6, 3'd1, 5, 1, 2, 10};
        scen[5] = '{3'd0, 3'd0, 0, 0, 2, 8};

        // Reset held while the clock runs and the input is busy.
        vdata_i = mkword(8'hAA, 1'b1);
        repeat (3) @(posedge VCLK);
        #1;
        check_zero("reset");
        nRST = 1'b1;

        // Zero delay: one cycle latency on both fields.
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, "ramp");

        for (int i = 0; i < 6; i++) begin
            set_req(scen[i].dly_c, scen[i].dly_s, scen[i].exp_c, scen[i].exp_s);
            for (int k = 0; k < scen[i].pre; k++) tick(1'b1, 1'b0, "scen_pre");
            tick(1'b0, 1'b1, "scen_fe");
            tick(1'b0, 1'b0, "scen_vslow");
            for (int k = 0; k < scen[i].post; k++) tick(1'b1, 1'b0, "scen_post");
        end

        // Request changes on the frame-edge cycle itself: applied there, no pending pulse.
        tick(1'b1, 1'b0, "same_pre");
        set_req(3'd2, 3'd0, 2, 0);
        tick(1'b0, 1'b1, "same_fe");
        tick(1'b0, 1'b0, "same_vslow");
        for (int k = 0; k < 6; k++) tick(1'b1, 1'b0, "same_post");

        // Request reverts to the active value before any frame edge.
        set_req(3'd4, 3'd0, 4, 0);
        tick(1'b1, 1'b0, "revert_up");
        set_req(3'd2, 3'd0, 2, 0);
        tick(1'b1, 1'b0, "revert_back");
        tick(1'b1, 1'b0, "revert_hold");
        tick(1'b0, 1'b1, "revert_fe");
        tick(1'b0, 1'b0, "revert_vslow");
        for (int k = 0; k < 5; k++) tick(1'b1, 1'b0, "revert_post");

        // Blanking clears colour only.
        blank_i = 1'b1;
        for (int k = 0; k < 3; k++) tick(1'b1, 1'b0, "blank_on");
        blank_i = 1'b0;
        for (int k = 0; k < 3; k++) tick(1'b1, 1'b0, "blank_off");

        // Mid-frame reset with act_c=4, act_s=3.
        set_req(3'd4, 3'd3, 4, 3);
        tick(1'b1, 1'b0, "mr_pre");
        tick(1'b0, 1'b1, "mr_fe");
        tick(1'b0, 1'b0, "mr_vslow");
        for (int k = 0; k < 6; k++) tick(1'b1, 1'b0, "mr_run");
        #2;
        nRST = 1'b0;
        #1;
        check_zero("mr_async");
        @(posedge VCLK);
        #1;
        check_zero("mr_held");
        nRST     = 1'b1;
        base     = t;
        lat_c    = 0;
        lat_s    = 0;
        prev_exp = '0;
        for (int k = 0; k < 2; k++) tick(1'b1, 1'b0, "mr_after");
        tick(1'b0, 1'b1, "mr_fe2");
        for (int k = 0; k < 8; k++) tick(1'b1, 1'b0, "mr_cleared");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
